// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_e;

    function automatic int unsigned calc_baud_cnt(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_module_if.sv
// Receiver-side bundle: serial line in, received byte and status pulses out.
interface uart_rx_module_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 uart_rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_busy;

    // master: the receiver itself; slave: line driver / byte consumer
    modport master (
        input  uart_rxd,
        output rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy
    );

    modport slave (
        output uart_rxd,
        input  rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async serial line plus a history flop for falling-edge detect.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rxd_i,
    output logic rxd_s_o,
    output logic rxd_fall_c_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to 1 so a line held low at reset release still looks like an edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxd_s_o      = sync_q;
    assign rxd_fall_c_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver: mid-bit sampling of start/data/[parity]/stop, one-cycle valid/error pulses.
// Optional parity bit is enabled with `define UART_RX_PARITY_EN.
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    uart_rx_module_if.master  rx_if
);

    localparam int unsigned BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD_RATE);
    localparam int unsigned BAUD_W   = $clog2(BAUD_CNT);
    localparam int unsigned BIT_W    = $clog2(DATA_BITS + 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_CNT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(BAUD_CNT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    if (BAUD_CNT < 8) begin : g_baud_chk
        $error("uart_rx_module: CLK_FREQ/BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
        $error("uart_rx_module: DATA_BITS must be 5..8");
    end
    if (PARITY_ODD > 1) begin : g_par_chk
        $error("uart_rx_module: PARITY_ODD must be 0 or 1");
    end

    uart_rx_state_e       state_q, state_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 rxd_s;
    logic                 rxd_fall_c;
    logic                 mid_start;
    logic                 mid_bit;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD_B = 1'(PARITY_ODD);
    logic par_mis_q, par_mis_d;
    logic rx_parity_err_q, rx_parity_err_d;
`endif

    uart_rx_sync u_sync (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rxd_i        (rx_if.uart_rxd),
        .rxd_s_o      (rxd_s),
        .rxd_fall_c_o (rxd_fall_c)
    );

    assign mid_start = (baud_cnt_q == HALF_LAST);
    assign mid_bit   = (baud_cnt_q == FULL_LAST);

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (rxd_fall_c) state_d = START;
            START:  if (mid_start)  state_d = rxd_s ? IDLE : DATA;
            DATA: begin
                if (mid_bit && (bit_cnt_q == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (mid_bit) state_d = STOP;
`endif
            STOP:   if (mid_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        baud_cnt_d     = baud_cnt_q + BAUD_W'(1);
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;
        rx_busy_d      = (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
        par_mis_d       = par_mis_q;
        rx_parity_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
            START: if (mid_start) baud_cnt_d = '0;
            DATA: begin
                if (mid_bit) begin
                    baud_cnt_d = '0;
                    shift_d    = {rxd_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_bit) begin
                    baud_cnt_d = '0;
                    par_mis_d  = rxd_s ^ (^shift_q) ^ PAR_ODD_B;
                end
            end
`endif
            STOP: begin
                if (mid_bit) begin
                    baud_cnt_d = '0;
                    if (rxd_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        rx_parity_err_d = par_mis_q;
`endif
                    end else begin
                        rx_frame_err_d = 1'b1;
                    end
                end
            end
            default: baud_cnt_d = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            baud_cnt_q     <= baud_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            par_mis_q       <= 1'b0;
            rx_parity_err_q <= 1'b0;
        end else begin
            par_mis_q       <= par_mis_d;
            rx_parity_err_q <= rx_parity_err_d;
        end
    end
    assign rx_if.rx_parity_err = rx_parity_err_q;
`else
    assign rx_if.rx_parity_err = 1'b0;
`endif

    assign rx_if.rx_data      = rx_data_q;
    assign rx_if.rx_valid     = rx_valid_q;
    assign rx_if.rx_frame_err = rx_frame_err_q;
    assign rx_if.rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module with a scoreboard of expected receive events.
module tb_uart_rx_module;

    localparam int unsigned BIT        = 434;
    localparam int unsigned PARITY_ODD = 0;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb_q[$];
    int   n_chk;
    int   n_pass;
    logic [7:0] last_good;
`ifdef UART_RX_PARITY_EN
    logic par_flip;
`endif

    uart_rx_module_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_module #(
        .CLK_FREQ   (50_000_000),
        .BAUD_RATE  (115200),
        .DATA_BITS  (8),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .rx_if     (rx_if.master)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input bit ferr, input logic [7:0] data, input bit perr);
        exp_t e;
        e.ferr = ferr;
        e.data = data;
        e.perr = perr;
        sb_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        rx_if.uart_rxd = b;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ 1'(PARITY_ODD) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_data"},  32'(rx_if.rx_data), 32'd0);
        chk({tag, "_valid"}, 32'(rx_if.rx_valid), 32'd0);
        chk({tag, "_ferr"},  32'(rx_if.rx_frame_err), 32'd0);
        chk({tag, "_perr"},  32'(rx_if.rx_parity_err), 32'd0);
        chk({tag, "_busy"},  32'(rx_if.rx_busy), 32'd0);
    endtask

    // Scoreboard: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n && (rx_if.rx_valid || rx_if.rx_frame_err)) begin
            chk("valid_ferr_excl", 32'(rx_if.rx_valid & rx_if.rx_frame_err), 32'd0);
            chk("event_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("event_kind_ferr", 32'(rx_if.rx_frame_err), 32'(e.ferr));
                chk("event_rx_data", 32'(rx_if.rx_data), 32'(e.data));
                if (!e.ferr) chk("event_parity_err", 32'(rx_if.rx_parity_err), 32'(e.perr));
            end
        end
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        last_good = 8'h00;
`ifdef UART_RX_PARITY_EN
        par_flip  = 1'b0;
`endif
        rst_n          = 1'b0;
        rx_if.uart_rxd = 1'b1;
        repeat (5) @(posedge clk);
        chk_idle_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // Single 0x55 frame
        push(1'b0, 8'h55, 1'b0);
        send_frame(8'h55, 1'b1);
        last_good = 8'h55;
        drain("t1_drain", 2000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t1_busy_after", 32'(rx_if.rx_busy), 32'd0);
        chk("t1_data_hold", 32'(rx_if.rx_data), 32'h55);

        // Back-to-back frames, zero idle gap
        push(1'b0, 8'hA5, 1'b0);
        push(1'b0, 8'h3C, 1'b0);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        last_good = 8'h3C;
        drain("t2_drain", 2000);
        repeat (BIT) @(posedge clk);

        // 100-clk glitch must be rejected by the start-bit check
        rx_if.uart_rxd = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t3_busy_on_glitch", 32'(rx_if.rx_busy), 32'd1);
        rx_if.uart_rxd = 1'b1;
        for (int i = 0; i < 217 && rx_if.rx_busy; i++) @(negedge clk);
        chk("t3_busy_dropped", 32'(rx_if.rx_busy), 32'd0);
        repeat (2000) @(posedge clk);
        chk("t3_no_events", 32'(sb_q.size()), 32'd0);

        // Stop bit low: frame error, data keeps previous byte, low line stays quiet
        push(1'b1, last_good, 1'b0);
        send_frame(8'hFF, 1'b0);
        repeat (3000) @(posedge clk);
        drain("t4_drain", 10);
        chk("t4_data_kept", 32'(rx_if.rx_data), 32'h3C);
        chk("t4_busy_low_held", 32'(rx_if.rx_busy), 32'd0);
        rx_if.uart_rxd = 1'b1;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("t4_busy_after_rise", 32'(rx_if.rx_busy), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Wrong then correct parity on 0x07
        par_flip = 1'b1;
        push(1'b0, 8'h07, 1'b1);
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        push(1'b0, 8'h07, 1'b0);
        send_frame(8'h07, 1'b1);
        last_good = 8'h07;
        drain("t5_drain", 2000);
        repeat (BIT) @(posedge clk);
`endif

        // Reset during data bit 4 of 0x81, then a clean 0x81
        rx_if.uart_rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        rx_if.uart_rxd = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(posedge clk);
        chk_idle_outputs("t6_in_reset");
        rx_if.uart_rxd = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        last_good = 8'h00;
        repeat (1000) @(posedge clk);
        chk_idle_outputs("t6_after_reset");
        push(1'b0, 8'h81, 1'b0);
        send_frame(8'h81, 1'b1);
        drain("t6_drain", 2000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t6_data_final", 32'(rx_if.rx_data), 32'h81);
        chk("t6_busy_final", 32'(rx_if.rx_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
